// File: rtl/reg_op_arbiter.sv
// reg_op_arbiter: shares a funsel-controlled register bank among NReq requesters.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module reg_op_arbiter #(
  parameter  int NBits = 4,
  parameter  int NRegs = 4,
  parameter  int NReq  = 4,
  localparam int SelW  = (NRegs > 1) ? $clog2(NRegs) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NReq-1:0]       req,
  input  logic [2*NReq-1:0]     req_funsel,
  input  logic [SelW*NReq-1:0]  req_sel,
  input  logic [NBits*NReq-1:0] req_data,
  input  logic [4*NReq-1:0]     req_count,
  output logic [NReq-1:0]       gnt,
  output logic                  done,
  output logic [NRegs-1:0]      reg_e,
  output logic [1:0]            reg_funsel,
  output logic [NBits-1:0]      reg_i
);

  localparam int IdxW = (NReq > 1) ? $clog2(NReq) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [1:0] {
    FS_CLEAR = 2'b00,
    FS_LOAD  = 2'b01,
    FS_DEC   = 2'b10,
    FS_INC   = 2'b11
  } funsel_t;

  state_t           state_q, state_d;
  logic [3:0]       remain_q, remain_d;
  logic [NReq-1:0]  gnt_d;
  logic             done_d;
  logic [NRegs-1:0] reg_e_d;
  logic [1:0]       reg_funsel_d;
  logic [NBits-1:0] reg_i_d;

`ifdef REG_ARB_ROUND_ROBIN_EN
  // Index where the next search begins: one past the last winner.
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
`endif

  logic             win_found;
  logic [IdxW-1:0]  win_idx;
  funsel_t          win_fs;
  logic [SelW-1:0]  win_sel;
  logic [NBits-1:0] win_data;
  logic [3:0]       win_cnt;
  logic [3:0]       win_eff;
  logic [NRegs-1:0] win_sel_oh;

  // Winner selection over the current request vector.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
`ifdef REG_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < NReq; i++) begin
      if (!win_found && req[(int'(rr_ptr_q) + i) % NReq]) begin
        win_found = 1'b1;
        win_idx   = IdxW'((int'(rr_ptr_q) + i) % NReq);
      end
    end
`else
    for (int i = NReq - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
      end
    end
`endif
  end

  // Operand extraction and effective repeat count for the winner.
  always_comb begin
    win_fs   = funsel_t'(req_funsel[int'(win_idx)*2 +: 2]);
    win_sel  = req_sel[int'(win_idx)*SelW +: SelW];
    win_data = req_data[int'(win_idx)*NBits +: NBits];
    win_cnt  = req_count[int'(win_idx)*4 +: 4];

    win_eff = 4'd1;
    unique case (win_fs)
      FS_CLEAR, FS_LOAD: win_eff = 4'd1;
      FS_DEC, FS_INC:    win_eff = (win_cnt == 4'd0) ? 4'd1 : win_cnt;
      default:           win_eff = 4'd1;
    endcase

    // An index beyond the bank matches no bit, so the bank sees no enable.
    win_sel_oh = '0;
    for (int r = 0; r < NRegs; r++) begin
      win_sel_oh[r] = (win_sel == SelW'(r));
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    gnt_d        = gnt;
    done_d       = 1'b0;
    reg_e_d      = reg_e;
    reg_funsel_d = reg_funsel;
    reg_i_d      = reg_i;
`ifdef REG_ARB_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d      = BUSY;
          remain_d     = win_eff;
          gnt_d        = {{(NReq-1){1'b0}}, 1'b1} << win_idx;
          reg_e_d      = win_sel_oh;
          reg_funsel_d = win_fs;
          reg_i_d      = win_data;
`ifdef REG_ARB_ROUND_ROBIN_EN
          rr_ptr_d     = (win_idx == IdxW'(NReq - 1)) ? '0 : win_idx + 1'b1;
`endif
        end else begin
          gnt_d        = '0;
          reg_e_d      = '0;
          reg_funsel_d = 2'b00;
          reg_i_d      = '0;
        end
      end

      BUSY: begin
        if (remain_q <= 4'd1) begin
          state_d      = IDLE;
          remain_d     = 4'd0;
          done_d       = 1'b1;
          gnt_d        = '0;
          reg_e_d      = '0;
          reg_funsel_d = 2'b00;
          reg_i_d      = '0;
        end else begin
          remain_d = remain_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset clears outputs at once, abandoning any operation without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      remain_q   <= 4'd0;
      gnt        <= '0;
      done       <= 1'b0;
      reg_e      <= '0;
      reg_funsel <= 2'b00;
      reg_i      <= '0;
`ifdef REG_ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      remain_q   <= remain_d;
      gnt        <= gnt_d;
      done       <= done_d;
      reg_e      <= reg_e_d;
      reg_funsel <= reg_funsel_d;
      reg_i      <= reg_i_d;
`ifdef REG_ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule
